// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store initiator between the execute/mem stage and a word-organised
// data memory. Takes one RV32I load or store per request, issues word-aligned accesses with
// byte-lane write enables, splits misaligned halfword/word accesses into two word accesses,
// reassembles and extends load data, and reports completion with a one-cycle response pulse.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_we, req_funct3    store flag and RV32I funct3 (size / signedness)
//   req_addr, req_wdata   byte address and right-justified store data
//   mem_addr              word-aligned byte address to data memory
//   mem_re                read strobe; mem_rd is valid the following cycle
//   mem_wr, mem_wd        byte-lane write enables and lane-positioned write data
//   mem_rd                word read data
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  extended load result and illegal-funct3 flag
module lsu_mem_initiator #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic [3:0]            mem_wr,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned WordW = DM_ADDRESS - 2;

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

  state_e                state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     buf0_q;
  logic                  err_q;

  logic                  accept;
  logic [1:0]            offset;
  logic [2:0]            size;
  logic [3:0]            size_mask;
  logic [7:0]            lane_en;
  logic                  split;
  logic [WordW-1:0]      word_next;
  logic [DATA_W-1:0]     wdata_sized;
  logic [DATA_W-1:0]     wdata_rot;
  logic [DATA_W-1:0]     wr_mask;
  logic [DATA_W-1:0]     ld_first;
  logic [DATA_W-1:0]     ld_word;
  logic [DATA_W-1:0]     ld_ext;
  logic [DATA_W-1:0]     resp_rdata_d;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return !(f3 inside {3'b000, 3'b001, 3'b010});
    end
    return f3 inside {3'b011, 3'b110, 3'b111};
  endfunction

  assign accept = req_valid && (state_q == StIdle);

  // Request latch and first-word buffer for split loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf0_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= is_illegal(req_we, req_funct3);
      end
      // mem_rd during ACC1 carries the word read in ACC0.
      if (state_q == StAcc1 && !we_q) begin
        buf0_q <= mem_rd;
      end
    end
  end

  // Access geometry derived from the latched request.
  always_comb begin
    offset = addr_q[1:0];
    unique case (funct3_q[1:0])
      2'b00: begin
        size        = 3'd1;
        size_mask   = 4'b0001;
        wdata_sized = {24'h0, wdata_q[7:0]};
      end
      2'b01: begin
        size        = 3'd2;
        size_mask   = 4'b0011;
        wdata_sized = {16'h0, wdata_q[15:0]};
      end
      default: begin
        size        = 3'd4;
        size_mask   = 4'b1111;
        wdata_sized = wdata_q;
      end
    endcase
    split     = ({1'b0, offset} + size) > 3'd4;
    // Low nibble: lanes of the first word; high nibble: lanes spilling into the next word.
    lane_en   = {4'b0000, size_mask} << offset;
    word_next = addr_q[DM_ADDRESS-1:2] + WordW'(1);
    // Byte k of the store data lands on lane (offset + k) % 4.
    unique case (offset)
      2'd0:    wdata_rot = wdata_sized;
      2'd1:    wdata_rot = {wdata_sized[23:0], wdata_sized[31:24]};
      2'd2:    wdata_rot = {wdata_sized[15:0], wdata_sized[31:16]};
      default: wdata_rot = {wdata_sized[7:0], wdata_sized[31:8]};
    endcase
  end

  // Load reassembly: bytes below lane 4 come from the first word, the rest from the current one.
  always_comb begin
    ld_first = split ? buf0_q : mem_rd;
    unique case (offset)
      2'd0:    ld_word = ld_first;
      2'd1:    ld_word = {mem_rd[7:0], ld_first[31:8]};
      2'd2:    ld_word = {mem_rd[15:0], ld_first[31:16]};
      default: ld_word = {mem_rd[23:0], ld_first[31:24]};
    endcase
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b010:  ld_ext = ld_word;
      3'b100:  ld_ext = {24'h0, ld_word[7:0]};
      3'b101:  ld_ext = {16'h0, ld_word[15:0]};
      default: ld_ext = '0;
    endcase
    resp_rdata_d = (we_q || err_q) ? '0 : ld_ext;
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = is_illegal(req_we, req_funct3) ? StResp : StAcc0;
        end
      end
      StAcc0:  state_d = split ? StAcc1 : StResp;
      StAcc1:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: memory-side outputs.
  always_comb begin
    req_ready = (state_q == StIdle);
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_wr    = 4'b0000;
    case (state_q)
      StAcc0: begin
        mem_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
        if (we_q) begin
          mem_wr = lane_en[3:0];
        end else begin
          mem_re = 1'b1;
        end
      end
      StAcc1: begin
        mem_addr = {word_next, 2'b00};
        if (we_q) begin
          mem_wr = lane_en[7:4];
        end else begin
          mem_re = 1'b1;
        end
      end
      default: ;
    endcase
    // Only lanes enabled this cycle carry data; everything else is driven to zero.
    wr_mask = {{8{mem_wr[3]}}, {8{mem_wr[2]}}, {8{mem_wr[1]}}, {8{mem_wr[0]}}};
    mem_wd  = wdata_rot & wr_mask;
  end

  // Registered response, issued on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= (state_q == StResp);
      resp_err   <= (state_q == StResp) && err_q;
      resp_rdata <= (state_q == StResp) ? resp_rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [8:0]  mem_addr;
  logic        mem_re;
  logic [3:0]  mem_wr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  lsu_mem_initiator #(
    .DM_ADDRESS(9),
    .DATA_W    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_wr    (mem_wr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  // Word memory: registered read, per-lane write.
  logic [31:0] mem [128];
  always @(posedge clk) begin
    if (mem_re) mem_rd <= mem[mem_addr[8:2]];
    for (int i = 0; i < 4; i++) begin
      if (mem_wr[i]) mem[mem_addr[8:2]][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nacc;
    logic [8:0]  a0;
    logic [3:0]  w0;
    logic [31:0] d0;
    logic [8:0]  a1;
    logic [3:0]  w1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  int          r_lat;
  int          r_nacc;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [8:0]  r_addr [2];
  logic [3:0]  r_wr [2];
  logic [31:0] r_wd [2];
  logic        r_re [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                     input int lat, input int nacc,
                     input logic [8:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                     input logic [8:0] a1, input logic [3:0] w1, input logic [31:0] d1);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    v.lat = lat; v.nacc = nacc;
    v.a0 = a0; v.w0 = w0; v.d0 = d0; v.a1 = a1; v.w1 = w1; v.d1 = d1;
    vecs.push_back(v);
  endtask

  // Issue one request from a negedge and observe until the response (bounded).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                        input logic [31:0] wdata);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = -1; r_nacc = 0; r_rdata = '0; r_err = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r_addr[k] = '0; r_wr[k] = '0; r_wd[k] = '0; r_re[k] = 1'b0;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_re || mem_wr != 4'b0000) begin
        if (r_nacc < 2) begin
          r_addr[r_nacc] = mem_addr; r_wr[r_nacc] = mem_wr;
          r_wd[r_nacc] = mem_wd; r_re[r_nacc] = mem_re;
        end
        r_nacc++;
      end
      if (resp_valid) begin
        r_lat = c - 1; r_rdata = resp_rdata; r_err = resp_err;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   busy_wr;
    int   quiet;

    //  we  f3      addr    wdata          rdata          err lat n  a0      w0    d0             a1      w1    d1
    add(1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h00000000, 0, 2, 1, 9'h010, 4'hF, 32'hDEADBEEF, 9'h0, 4'h0, 32'h0);
    add(0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 0, 2, 1, 9'h010, 4'h0, 32'h0,        9'h0, 4'h0, 32'h0);
    add(1, 3'b000, 9'h013, 32'h123456A5, 32'h00000000, 0, 2, 1, 9'h010, 4'h8, 32'hA5000000, 9'h0, 4'h0, 32'h0);
    add(0, 3'b000, 9'h013, 32'h0,        32'hFFFFFFA5, 0, 2, 1, 9'h010, 4'h0, 32'h0,        9'h0, 4'h0, 32'h0);
    add(0, 3'b100, 9'h013, 32'h0,        32'h000000A5, 0, 2, 1, 9'h010, 4'h0, 32'h0,        9'h0, 4'h0, 32'h0);
    add(1, 3'b010, 9'h020, 32'h44332211, 32'h00000000, 0, 2, 1, 9'h020, 4'hF, 32'h44332211, 9'h0, 4'h0, 32'h0);
    add(1, 3'b010, 9'h024, 32'h88776655, 32'h00000000, 0, 2, 1, 9'h024, 4'hF, 32'h88776655, 9'h0, 4'h0, 32'h0);
    add(0, 3'b010, 9'h022, 32'h0,        32'h66554433, 0, 3, 2, 9'h020, 4'h0, 32'h0,        9'h024, 4'h0, 32'h0);
    add(1, 3'b001, 9'h1FF, 32'h0000BEEF, 32'h00000000, 0, 3, 2, 9'h1FC, 4'h8, 32'hEF000000, 9'h000, 4'h1, 32'h000000BE);
    add(0, 3'b101, 9'h1FF, 32'h0,        32'h0000BEEF, 0, 3, 2, 9'h1FC, 4'h0, 32'h0,        9'h000, 4'h0, 32'h0);
    add(0, 3'b001, 9'h1FF, 32'h0,        32'hFFFFBEEF, 0, 3, 2, 9'h1FC, 4'h0, 32'h0,        9'h000, 4'h0, 32'h0);
    add(1, 3'b001, 9'h003, 32'h000080FF, 32'h00000000, 0, 3, 2, 9'h000, 4'h8, 32'hFF000000, 9'h004, 4'h1, 32'h00000080);
    add(0, 3'b101, 9'h003, 32'h0,        32'h000080FF, 0, 3, 2, 9'h000, 4'h0, 32'h0,        9'h004, 4'h0, 32'h0);
    add(0, 3'b001, 9'h003, 32'h0,        32'hFFFF80FF, 0, 3, 2, 9'h000, 4'h0, 32'h0,        9'h004, 4'h0, 32'h0);
    add(1, 3'b010, 9'h005, 32'hCAFEF00D, 32'h00000000, 0, 3, 2, 9'h004, 4'hE, 32'hFEF00D00, 9'h008, 4'h1, 32'h000000CA);
    add(0, 3'b010, 9'h005, 32'h0,        32'hCAFEF00D, 0, 3, 2, 9'h004, 4'h0, 32'h0,        9'h008, 4'h0, 32'h0);
    add(1, 3'b001, 9'h012, 32'h00001234, 32'h00000000, 0, 2, 1, 9'h010, 4'hC, 32'h12340000, 9'h0, 4'h0, 32'h0);
    add(0, 3'b001, 9'h012, 32'h0,        32'h00001234, 0, 2, 1, 9'h010, 4'h0, 32'h0,        9'h0, 4'h0, 32'h0);
    add(0, 3'b101, 9'h011, 32'h0,        32'h000034BE, 0, 2, 1, 9'h010, 4'h0, 32'h0,        9'h0, 4'h0, 32'h0);
    add(1, 3'b000, 9'h010, 32'h0000007E, 32'h00000000, 0, 2, 1, 9'h010, 4'h1, 32'h0000007E, 9'h0, 4'h0, 32'h0);
    add(0, 3'b000, 9'h010, 32'h0,        32'h0000007E, 0, 2, 1, 9'h010, 4'h0, 32'h0,        9'h0, 4'h0, 32'h0);
    add(0, 3'b011, 9'h010, 32'h0,        32'h00000000, 1, 1, 0, 9'h0,   4'h0, 32'h0,        9'h0, 4'h0, 32'h0);
    add(1, 3'b100, 9'h010, 32'hFFFFFFFF, 32'h00000000, 1, 1, 0, 9'h0,   4'h0, 32'h0,        9'h0, 4'h0, 32'h0);
    add(0, 3'b111, 9'h013, 32'h0,        32'h00000000, 1, 1, 0, 9'h0,   4'h0, 32'h0,        9'h0, 4'h0, 32'h0);
    add(1, 3'b011, 9'h010, 32'hFFFFFFFF, 32'h00000000, 1, 1, 0, 9'h0,   4'h0, 32'h0,        9'h0, 4'h0, 32'h0);
    add(0, 3'b010, 9'h010, 32'h0,        32'h1234BE7E, 0, 2, 1, 9'h010, 4'h0, 32'h0,        9'h0, 4'h0, 32'h0);
    add(1, 3'b010, 9'h018, 32'h00000000, 32'h00000000, 0, 2, 1, 9'h018, 4'hF, 32'h0,        9'h0, 4'h0, 32'h0);
    add(1, 3'b010, 9'h01C, 32'h00000000, 32'h00000000, 0, 2, 1, 9'h01C, 4'hF, 32'h0,        9'h0, 4'h0, 32'h0);

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_re", 64'(mem_re), 64'd0);
    check("rst_wr", 64'(mem_wr), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wd", 64'(mem_wd), 64'd0);
    check("rst_resp", {31'd0, resp_valid, resp_err, resp_rdata}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      do_req(v.we, v.f3, v.addr, v.wdata);
      check($sformatf("v%0d_rdata", i), 64'(r_rdata), 64'(v.rdata));
      check($sformatf("v%0d_err", i), 64'(r_err), 64'(v.err));
      check($sformatf("v%0d_lat", i), 64'(r_lat), 64'(v.lat));
      check($sformatf("v%0d_nacc", i), 64'(r_nacc), 64'(v.nacc));
      for (int k = 0; k < v.nacc && k < 2; k++) begin
        if (k == 0)
          check($sformatf("v%0d_acc0", i), {r_addr[0], r_wr[0], r_wd[0], r_re[0]},
                {v.a0, v.w0, v.d0, !v.we});
        else
          check($sformatf("v%0d_acc1", i), {r_addr[1], r_wr[1], r_wd[1], r_re[1]},
                {v.a1, v.w1, v.d1, !v.we});
      end
    end

    // A request presented while busy must be ignored.
    busy_wr = 0;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h024; req_wdata = '0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_we = 1'b1;
    @(negedge clk);
    check("busy_ready1", 64'(req_ready), 64'd0);
    if (mem_wr != 4'b0000) busy_wr++;
    @(negedge clk);
    check("busy_ready2", 64'(req_ready), 64'd0);
    if (mem_wr != 4'b0000) busy_wr++;
    req_valid = 1'b0;
    @(negedge clk);
    check("busy_resp", {resp_valid, req_ready, resp_rdata}, {1'b1, 1'b1, 32'h88776655});
    check("busy_nowrite", 64'(busy_wr), 64'd0);
    do_req(1'b0, 3'b010, 9'h024, 32'h0);
    check("busy_mem", 64'(r_rdata), 64'h88776655);

    // Reset during ACC0 of a split store: only the first half lands, no response.
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 9'h019; req_wdata = 32'h11223344;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_acc0", {mem_addr, mem_wr, mem_wd}, {9'h018, 4'hE, 32'h22334400});
    reset = 1'b1;
    @(negedge clk);
    check("mid_idle", {req_ready, mem_re, mem_wr, mem_addr, resp_valid},
          {1'b1, 1'b0, 4'h0, 9'h0, 1'b0});
    check("mid_wd", 64'(mem_wd), 64'd0);
    reset = 1'b0;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid || mem_wr != 4'b0000 || mem_re) quiet++;
    end
    check("mid_quiet", 64'(quiet), 64'd0);
    do_req(1'b0, 3'b010, 9'h018, 32'h0);
    check("mid_word0", 64'(r_rdata), 64'h22334400);
    do_req(1'b0, 3'b010, 9'h01C, 32'h0);
    check("mid_word1", 64'(r_rdata), 64'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
